bus_arbiter: RTL



---
 rtl/bus_arbiter.sv | 134 +++++++++++++
 1 files changed

// File: rtl/bus_arbiter.sv
// Two-master, one-slave round-robin bus arbiter with a registered owner and a
// timeout watchdog that force-completes a transaction the slave never acknowledges.
module bus_arbiter #(
  parameter int unsigned TIMEOUT   = 16,
  parameter logic [31:0] ERR_RDATA = 32'h0000_0000
) (
  input  logic        i_CLK,
  input  logic        i_RST_N,
  input  logic        i_M0_REQ,
  input  logic [31:0] i_M0_ADDR,
  input  logic [31:0] i_M0_WDATA,
  input  logic        i_M0_WE,
  input  logic        i_M0_RE,
  input  logic [1:0]  i_M0_HB,
  output logic        o_M0_GNT,
  output logic [31:0] o_M0_RDATA,
  output logic        o_M0_ERR,
  input  logic        i_M1_REQ,
  input  logic [31:0] i_M1_ADDR,
  input  logic [31:0] i_M1_WDATA,
  input  logic        i_M1_WE,
  input  logic        i_M1_RE,
  input  logic [1:0]  i_M1_HB,
  output logic        o_M1_GNT,
  output logic [31:0] o_M1_RDATA,
  output logic        o_M1_ERR,
  output logic        o_S_CS,
  output logic [31:0] o_S_ADDR,
  output logic [31:0] o_S_WDATA,
  output logic        o_S_WE,
  output logic        o_S_RE,
  output logic [1:0]  o_S_HB,
  input  logic [31:0] i_S_RDATA,
  input  logic        i_S_ACK,
  output logic        o_BUSY
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_e;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        last_owner_q, last_owner_d;
  logic [7:0]  tmo_cnt_q, tmo_cnt_d;
  logic        owning, tmo_hit, done;
  logic [31:0] resp_rdata;

  assign owning  = (state_q != IDLE);
  assign tmo_hit = (tmo_cnt_q == TMO_LAST);
  // An ACK in the final watchdog cycle still counts as a normal completion.
  assign done    = owning && (i_S_ACK || tmo_hit);

  always_comb begin
    // NOTE: every signal assigned here gets a default first so no latch is inferred.
    state_d      = state_q;
    last_owner_d = last_owner_q;
    tmo_cnt_d    = tmo_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (i_M0_REQ && i_M1_REQ) state_d = last_owner_q ? OWN0 : OWN1;
        else if (i_M0_REQ)        state_d = OWN0;
        else if (i_M1_REQ)        state_d = OWN1;
      end
      OWN0, OWN1: begin
        if (done) begin
          state_d      = IDLE;
          last_owner_d = (state_q == OWN1);
          tmo_cnt_d    = '0;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!i_RST_N) begin
      state_q      <= IDLE;
      last_owner_q <= 1'b1;
      tmo_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      tmo_cnt_q    <= tmo_cnt_d;
    end
  end

  always_comb begin
    o_S_CS    = 1'b0;
    o_S_ADDR  = '0;
    o_S_WDATA = '0;
    o_S_WE    = 1'b0;
    o_S_RE    = 1'b0;
    o_S_HB    = '0;
    unique case (state_q)
      OWN0: begin
        o_S_CS    = 1'b1;
        o_S_ADDR  = i_M0_ADDR;
        o_S_WDATA = i_M0_WDATA;
        o_S_WE    = i_M0_WE;
        o_S_RE    = i_M0_RE;
        o_S_HB    = i_M0_HB;
      end
      OWN1: begin
        o_S_CS    = 1'b1;
        o_S_ADDR  = i_M1_ADDR;
        o_S_WDATA = i_M1_WDATA;
        o_S_WE    = i_M1_WE;
        o_S_RE    = i_M1_RE;
        o_S_HB    = i_M1_HB;
      end
      default: ;
    endcase
  end

  assign resp_rdata = i_S_ACK ? i_S_RDATA : ERR_RDATA;

  assign o_M0_GNT   = done && (state_q == OWN0);
  assign o_M0_RDATA = o_M0_GNT ? resp_rdata : '0;
  assign o_M0_ERR   = o_M0_GNT && !i_S_ACK;

  assign o_M1_GNT   = done && (state_q == OWN1);
  assign o_M1_RDATA = o_M1_GNT ? resp_rdata : '0;
  assign o_M1_ERR   = o_M1_GNT && !i_S_ACK;

  assign o_BUSY = owning;

endmodule
